// File: rtl/imm_ext_pkg.sv
// Shared types for the pipelined immediate extender: mode/state enums and the
// default-width result entry. BRANCH behaviour is selected by IMM_EXT_BRANCH_EN.
package imm_ext_pkg;

  localparam int unsigned IN_W_DEF  = 16;
  localparam int unsigned OUT_W_DEF = 32;
  localparam int unsigned TAG_W_DEF = 5;

  typedef enum logic [1:0] {
    SIGN   = 2'b00,
    ZERO   = 2'b01,
    UPPER  = 2'b10,
    BRANCH = 2'b11
  } ext_mode_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  typedef struct packed {
    logic [OUT_W_DEF-1:0] imm;
    logic [TAG_W_DEF-1:0] tag;
    logic                 neg;
    logic                 illegal;
  } ext_entry_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (imm, mode) -> extended value and flags.
// With IMM_EXT_BRANCH_EN undefined, mode 11 falls back to SIGN and flags illegal.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] imm_o,
  output logic             neg_o,
  output logic             illegal_o
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  ext_mode_t        mode;

  assign mode      = ext_mode_t'(mode_i);
  assign sign_ext  = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
  assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, imm_i};
  assign upper_ext = {imm_i, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    imm_o     = sign_ext;
    illegal_o = 1'b0;
    neg_o     = imm_i[IN_W-1] & ((mode == SIGN) | (mode == BRANCH));
    case (mode)
      SIGN:  imm_o = sign_ext;
      ZERO:  imm_o = zero_ext;
      UPPER: imm_o = upper_ext;
      BRANCH: begin
`ifdef IMM_EXT_BRANCH_EN
        imm_o = {sign_ext[OUT_W-3:0], 2'b00};
`else
        imm_o     = sign_ext;
        illegal_o = 1'b1;
`endif
      end
      default: imm_o = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with valid/ready handshake and a 2-entry skid
// buffer (output register + skid register). Optional macro: IMM_EXT_BRANCH_EN.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg,
  output logic             out_illegal
);

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must be >= 2");
  end
  if (OUT_W <= IN_W) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be greater than IN_W");
  end

  // Same layout as ext_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
    logic             neg;
    logic             illegal;
  } entry_t;

  state_t state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;

  logic [OUT_W-1:0] core_imm;
  logic             core_neg;
  logic             core_illegal;
  logic             accept;
  logic             fire;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_i     (in_imm),
    .mode_i    (in_mode),
    .imm_o     (core_imm),
    .neg_o     (core_neg),
    .illegal_o (core_illegal)
  );

  always_comb begin
    new_entry.imm     = core_imm;
    new_entry.tag     = in_tag;
    new_entry.neg     = core_neg;
    new_entry.illegal = core_illegal;
  end

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && fire) begin
          out_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = FULL;
        end else if (fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (fire) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_neg     = out_q.neg;
  assign out_illegal = out_q.illegal;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined successor to the combinational 16→32 sign extender. Takes an IN_W-bit immediate plus a mode select and produces an OUT_W-bit result: sign-extend, zero-extend, upper-placement (LUI) or branch-offset.
Sits between decode and the ID/EX boundary. Has a valid/ready handshake and a 2-entry skid buffer, so decode stalls never drop an immediate.
Carries an opaque tag (e.g. rd/PC index) alongside each result.

Parameters:
IN_W, 16, immediate input width; must be ≥2.
OUT_W, 32, result width; must be > IN_W (elaboration-time assertion).
TAG_W, 5, width of sideband tag carried with each immediate.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  upstream offers an immediate
in_ready  out  1  block can accept this cycle
in_imm  in  IN_W  raw immediate
in_mode  in  2  ext_mode_t: 00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result available
out_ready  in  1  downstream accepts
out_imm  out  OUT_W  extended result
out_tag  out  TAG_W  tag matching out_imm
out_neg  out  1  input MSB was 1 and mode was SIGN or BRANCH
out_illegal  out  1  mode 11 requested while BRANCH support is compiled out

Behaviour:
- Arithmetic is applied combinationally on the input side, then the result is registered.
  - SIGN: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
  - ZERO: {(OUT_W-IN_W){0}, imm}.
  - UPPER: imm occupies bits [OUT_W-1:OUT_W-IN_W]; lower bits are 0. With 16/32 this is 0xABCD → 0xABCD0000.
  - BRANCH: SIGN result << 2, truncated to OUT_W; the top 2 bits are discarded.
- Handshake:
  - Accept = in_valid & in_ready.
  - Fire = out_valid & out_ready.
  - in_valid may drop without an accept. Once out_valid is asserted, out_imm, out_tag and the flags stay stable until fire.
- Latency: an immediate accepted on edge n is presented with out_valid=1 after edge n (1 cycle). Throughput is 1 per cycle while out_ready=1.
- State machine (state_t):
  - EMPTY: accept → ONE (load out reg).
  - ONE:
    - accept & fire → ONE (reload out reg).
    - accept & !fire → FULL (load skid reg).
    - !accept & fire → EMPTY.
    - otherwise hold.
  - FULL: in_ready=0; fire → ONE (out reg ← skid reg). No accept is possible in FULL.
- in_ready = (state != FULL) & !rst. It is decoded from registered state only and has no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Ordering is strict FIFO: the skid entry is always older than any later accept.
- Reset (async, any time, including mid-transfer): state=EMPTY, out_valid=0, out_imm=0, out_tag=0, out_neg=0, out_illegal=0. Pending entries are discarded. in_ready goes to 1 on the first cycle after rst deasserts.
- Unknown in_mode bits while in_valid=1 are a protocol violation; the bench flags them with an assertion.

Optional Feature:
Macro: IMM_EXT_BRANCH_EN.
- Defined: mode 11 produces the BRANCH result; out_illegal is always 0.
- Undefined: mode 11 produces the SIGN result and out_illegal=1 for that entry, carried through the skid buffer with its data. No shifter logic is synthesised.

Decomposition:
- Package imm_ext_pkg holds:
  - ext_mode_t enum (SIGN, ZERO, UPPER, BRANCH).
  - state_t enum (EMPTY, ONE, FULL).
  - Packed struct ext_entry_t {imm, tag, neg, illegal}. It is parameterised via localparams, so the defaults live in the package.
- One sub-module, imm_ext_core: purely combinational, (imm, mode) → ext_entry_t fields. Reused by the top for the input-side compute.
- The top holds the FSM plus the two ext_entry_t registers.

Test Plan:
- Defaults, out_ready=1, SIGN 0x8000 then ZERO 0x8000 on consecutive cycles → out 0xFFFF8000 (neg=1), then 0x00008000 (neg=0); each is 1 cycle after accept.
- UPPER 0xABCD, tag 7 → out_imm 0xABCD0000, out_tag 7. With IN_W=12, OUT_W=20, UPPER 0xFFF → 0xFFF00.
- Backpressure: out_ready=0, stream tags 1,2,3 → tags 1,2 accepted (FULL), in_ready=0, tag 3 held. Release → outputs 1,2,3 in order, no loss or duplication.
- BRANCH 0xFFFF with macro defined → 0xFFFFFFFC, illegal=0. Without the macro → 0xFFFFFFFF, illegal=1.
- Assert rst while in FULL → out_valid=0 immediately (async), outputs zero. After release, in_ready=1 and the next accept of 0x0004 SIGN → 0x00000004.
- Random valid/ready toggling for 10k transactions against a scoreboard model → exact in-order match, and out_* stable whenever out_valid & !out_ready.
